// File: rtl/btn_pkg.sv
// -----------------------------------------------------------------------------
// btn_pkg
// Shared constants and types for the push-button conditioning bank that feeds
// the dice-roller counter.
//   - BTN_D4..BTN_D100 : channel index of each die button on ui_in[6:0]
//   - *_DEFAULT        : default sizes for a 32768 Hz clock
//   - press_state_t    : per-channel press / auto-repeat FSM states
//   - cnt_w()          : counter width helper that never returns 0
// -----------------------------------------------------------------------------
package btn_pkg;

    localparam int BTN_D4   = 0;
    localparam int BTN_D6   = 1;
    localparam int BTN_D8   = 2;
    localparam int BTN_D10  = 3;
    localparam int BTN_D12  = 4;
    localparam int BTN_D20  = 5;
    localparam int BTN_D100 = 6;

    localparam int N_BTN_DEFAULT           = 7;
    localparam int DEBOUNCE_CYCLES_DEFAULT = 328;    // ~10 ms
    localparam int HOLD_CYCLES_DEFAULT     = 16384;  // ~0.5 s
    localparam int REPEAT_CYCLES_DEFAULT   = 3277;   // ~0.1 s

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HELD   = 2'd1,
        REPEAT = 2'd2
    } press_state_t;

    // Bits needed to count 0..n-1; at least one bit so tiny values still build.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int max_i(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_debounce_chan.sv
// -----------------------------------------------------------------------------
// btn_debounce_chan
// One button channel: 2-flop synchroniser, debounce counter and press /
// auto-repeat FSM.
// Ports:
//   clk     : system clock
//   rst     : asynchronous active-high reset, clears every flop
//   raw_i   : raw asynchronous pin, active-high
//   lvl_o   : debounced level (registered)
//   press_o : one-cycle pulse per accepted press and per auto-repeat (registered)
// -----------------------------------------------------------------------------
module btn_debounce_chan
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int HOLD_CYCLES     = HOLD_CYCLES_DEFAULT,
    parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEFAULT,
    parameter int REPEAT_EN       = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic lvl_o,
    output logic press_o
);

    localparam int CW = cnt_w(DEBOUNCE_CYCLES);
    localparam int HW = cnt_w(max_i(HOLD_CYCLES, REPEAT_CYCLES));

    localparam logic [CW-1:0] CNT_TERM  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_TERM = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] REP_TERM  = HW'(REPEAT_CYCLES - 1);

    // ---------------- synchroniser ----------------
    logic [1:0] sync_q;
    logic       sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[0], raw_i};
    end

    assign sync = sync_q[1];

    // ---------------- debounce ----------------
    logic [CW-1:0] cnt_q, cnt_d;
    logic          lvl_q, lvl_d;
    logic          rise;

    always_comb begin
        cnt_d = cnt_q;
        lvl_d = lvl_q;
        if (sync == lvl_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_TERM) begin
            lvl_d = sync;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            lvl_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            lvl_q <= lvl_d;
        end
    end

    // The FSM reacts on the same edge that lvl commits, so the press pulse
    // lines up with the first cycle lvl_o reads 1.
    assign rise = ~lvl_q & lvl_d;

    // ---------------- press / repeat FSM ----------------
    press_state_t  state_q;
    logic [HW-1:0] hcnt_q;
    logic          press_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            hcnt_q  <= '0;
            press_q <= 1'b0;
        end else begin
            press_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        press_q <= 1'b1;
                        hcnt_q  <= '0;
                        state_q <= HELD;
                    end
                end
                HELD: begin
                    if (!lvl_q) begin
                        hcnt_q  <= '0;
                        state_q <= IDLE;
                    end else if (REPEAT_EN != 0) begin
                        if (hcnt_q == HOLD_TERM) begin
                            press_q <= 1'b1;
                            hcnt_q  <= '0;
                            state_q <= REPEAT;
                        end else begin
                            hcnt_q <= hcnt_q + 1'b1;
                        end
                    end
                end
                REPEAT: begin
                    if (!lvl_q) begin
                        hcnt_q  <= '0;
                        state_q <= IDLE;
                    end else if (hcnt_q == REP_TERM) begin
                        press_q <= 1'b1;
                        hcnt_q  <= '0;
                    end else begin
                        hcnt_q <= hcnt_q + 1'b1;
                    end
                end
                default: begin
                    hcnt_q  <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign lvl_o   = lvl_q;
    assign press_o = press_q;

endmodule

// File: rtl/btn_debounce_bank.sv
// -----------------------------------------------------------------------------
// btn_debounce_bank
// Conditions the raw dice-roller buttons: N_BTN independent channels, each
// synchronised, debounced and turned into a level plus press/repeat pulses.
// Ports:
//   clk       : system clock (32768 Hz)
//   rst       : asynchronous active-high reset
//   btn_raw   : raw asynchronous pins, active-high
//   btn_lvl   : debounced levels
//   btn_press : one-cycle pulse per accepted press / auto-repeat
//   any_lvl   : OR of btn_lvl
//   any_press : OR of btn_press
// -----------------------------------------------------------------------------
module btn_debounce_bank
    import btn_pkg::*;
#(
    parameter int N_BTN           = N_BTN_DEFAULT,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int HOLD_CYCLES     = HOLD_CYCLES_DEFAULT,
    parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEFAULT,
    parameter int REPEAT_EN       = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_lvl,
    output logic [N_BTN-1:0] btn_press,
    output logic             any_lvl,
    output logic             any_press
);

    // Adjacent repeat pulses would merge into one long pulse downstream.
    if (REPEAT_CYCLES < 2) begin : g_bad_repeat
        $error("btn_debounce_bank: REPEAT_CYCLES must be >= 2");
    end
    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535) begin : g_bad_deb
        $error("btn_debounce_bank: DEBOUNCE_CYCLES must be in 2..65535");
    end

    for (genvar g = 0; g < N_BTN; g++) begin : g_chan
        btn_debounce_chan #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_CYCLES     (HOLD_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES),
            .REPEAT_EN       (REPEAT_EN)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .raw_i   (btn_raw[g]),
            .lvl_o   (btn_lvl[g]),
            .press_o (btn_press[g])
        );
    end

    // ORs of registered signals: glitch-free, no added latency.
    assign any_lvl   = |btn_lvl;
    assign any_press = |btn_press;

endmodule
